// File: rtl/multiplexer_binary_pipelined_pkg.sv
// Shared constants and elaboration helpers for the pipelined binary multiplexer.
// Optional error counter width lives here (feature macro: MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN).
package multiplexer_pkg;

  localparam int ERR_COUNT_WIDTH = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Each stage carries the selected word plus its out-of-range flag.
  function automatic int payload_width(input int word_width);
    return word_width + 1;
  endfunction

endpackage

// File: rtl/multiplexer_binary_pipelined_if.sv
// Producer/consumer bus of the pipelined binary multiplexer.
// master = the side driving words and consuming results; slave = the multiplexer.
interface multiplexer_binary_pipelined_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 5,
  parameter int ADDR_WIDTH  = 3
) ();

  localparam int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT;

  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_WIDTH-1:0]  selector;
  logic [TOTAL_WIDTH-1:0] words_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_WIDTH-1:0]  word_out;
  logic                   out_of_range;

  modport master (
    output in_valid, selector, words_in, out_ready,
    input  in_ready, out_valid, word_out, out_of_range
  );

  modport slave (
    input  in_valid, selector, words_in, out_ready,
    output in_ready, out_valid, word_out, out_of_range
  );

endinterface

// File: rtl/multiplexer_binary_pipelined_pipeline_handshake_stage.sv
// Single valid/ready register stage; accepts when empty or when downstream drains it this cycle.
module pipeline_handshake_stage #(
  parameter int PAYLOAD_WIDTH = 9
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_data
);

  logic                     valid_q, valid_d;
  logic [PAYLOAD_WIDTH-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/multiplexer_binary_pipelined.sv
// Binary-selected N:1 word multiplexer feeding a PIPE_DEPTH-stage valid/ready pipeline.
// Optional saturating out-of-range counter: MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN.
module multiplexer_binary_pipelined
  import multiplexer_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 5,
  parameter int ADDR_WIDTH  = 3,
  parameter int PIPE_DEPTH  = 2
) (
  input logic clock,
  input logic clear_n,
  multiplexer_binary_pipelined_if.slave bus
`ifdef MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN
  ,
  output logic [ERR_COUNT_WIDTH-1:0] error_count
`endif
);

  localparam int TOTAL_WIDTH   = WORD_WIDTH * INPUT_COUNT;
  localparam int PAYLOAD_WIDTH = payload_width(WORD_WIDTH);

  if (ADDR_WIDTH < clog2(INPUT_COUNT)) begin : g_bad_addr_width
    $error("ADDR_WIDTH %0d cannot index %0d inputs", ADDR_WIDTH, INPUT_COUNT);
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_pipe_depth
    $error("PIPE_DEPTH %0d outside 1..4", PIPE_DEPTH);
  end

  logic [TOTAL_WIDTH-1:0] words_flat;
  logic [INPUT_COUNT-1:0] onehot;
  logic [WORD_WIDTH-1:0]  selected_word;
  logic                   sel_out_of_range;

  assign words_flat = bus.words_in;

  // An unmatched selector leaves onehot empty, which zeroes the word and flags it.
  always_comb begin
    onehot        = '0;
    selected_word = '0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      onehot[i]     = (bus.selector == ADDR_WIDTH'(i));
      selected_word = selected_word |
                      (words_flat[i*WORD_WIDTH +: WORD_WIDTH] & {WORD_WIDTH{onehot[i]}});
    end
    sel_out_of_range = ~|onehot;
  end

  logic                     stg_valid [PIPE_DEPTH+1];
  logic                     stg_ready [PIPE_DEPTH+1];
  logic [PAYLOAD_WIDTH-1:0] stg_data  [PIPE_DEPTH+1];

  assign stg_valid[0]          = bus.in_valid;
  assign stg_data[0]           = {sel_out_of_range, selected_word};
  assign bus.in_ready          = stg_ready[0];
  assign stg_ready[PIPE_DEPTH] = bus.out_ready;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    pipeline_handshake_stage #(
      .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
    ) u_stage (
      .clock    (clock),
      .clear_n  (clear_n),
      .in_valid (stg_valid[k]),
      .in_ready (stg_ready[k]),
      .in_data  (stg_data[k]),
      .out_valid(stg_valid[k+1]),
      .out_ready(stg_ready[k+1]),
      .out_data (stg_data[k+1])
    );
  end

  assign bus.out_valid                   = stg_valid[PIPE_DEPTH];
  assign {bus.out_of_range, bus.word_out} = stg_data[PIPE_DEPTH];

`ifdef MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN
  logic [ERR_COUNT_WIDTH-1:0] error_count_q, error_count_d;

  always_comb begin
    error_count_d = error_count_q;
    if (bus.in_valid && stg_ready[0] && sel_out_of_range && (error_count_q != '1)) begin
      error_count_d = error_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      error_count_q <= '0;
    end else begin
      error_count_q <= error_count_d;
    end
  end

  assign error_count = error_count_q;
`endif

endmodule

// File: tb/tb_multiplexer_binary_pipelined.sv
// Directed vector table plus handshake corner sequences and a scoreboarded random run.
module tb_multiplexer_binary_pipelined;

  localparam int WW     = 8;
  localparam int IC     = 5;
  localparam int AW     = 3;
  localparam int PD     = 2;
  localparam int NVEC   = 11;
  localparam int N_RAND = 3000;

  localparam logic [WW*IC-1:0] W_SEQ = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
  localparam logic [WW*IC-1:0] W_MIX = {8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h80};

  typedef struct {
    logic [AW-1:0]    sel;
    logic [WW*IC-1:0] words;
    logic [WW-1:0]    exp_word;
    logic             exp_oor;
  } vec_t;

  typedef struct {
    logic [WW:0] res;
    int          cyc;
  } sb_t;

  logic clock = 1'b0;
  logic clear_n;
  always #5 clock = ~clock;

  multiplexer_binary_pipelined_if #(.WORD_WIDTH(WW), .INPUT_COUNT(IC), .ADDR_WIDTH(AW)) bus_if ();

`ifdef MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN
  logic [15:0] error_count;
`endif

  multiplexer_binary_pipelined #(
    .WORD_WIDTH (WW),
    .INPUT_COUNT(IC),
    .ADDR_WIDTH (AW),
    .PIPE_DEPTH (PD)
  ) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .bus    (bus_if)
`ifdef MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN
    ,
    .error_count(error_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  vec_t vecs [NVEC];
  sb_t  sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WW:0] model(input logic [AW-1:0] sel, input logic [WW*IC-1:0] words);
    if (int'(sel) < IC) return {1'b0, words[int'(sel)*WW +: WW]};
    return {1'b1, {WW{1'b0}}};
  endfunction

  initial begin
    vecs[0]  = '{3'd0, W_SEQ, 8'h10, 1'b0};
    vecs[1]  = '{3'd1, W_SEQ, 8'h11, 1'b0};
    vecs[2]  = '{3'd2, W_SEQ, 8'h12, 1'b0};
    vecs[3]  = '{3'd3, W_SEQ, 8'h13, 1'b0};
    vecs[4]  = '{3'd4, W_SEQ, 8'h14, 1'b0};
    vecs[5]  = '{3'd5, W_SEQ, 8'h00, 1'b1};
    vecs[6]  = '{3'd6, W_SEQ, 8'h00, 1'b1};
    vecs[7]  = '{3'd7, W_MIX, 8'h00, 1'b1};
    vecs[8]  = '{3'd4, W_MIX, 8'hA5, 1'b0};
    vecs[9]  = '{3'd2, W_MIX, 8'hFF, 1'b0};
    vecs[10] = '{3'd0, W_MIX, 8'h80, 1'b0};

    // Reset held three edges with a transfer offered throughout.
    clear_n          = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.selector  = 3'd1;
    bus_if.words_in  = W_SEQ;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_out_valid", bus_if.out_valid, 0);
      check("reset_word_out", bus_if.word_out, 0);
      check("reset_out_of_range", bus_if.out_of_range, 0);
    end
    clear_n         = 1'b1;
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_idle", bus_if.out_valid, 0);
    end

    // Back-to-back vectors, results exactly PD edges after acceptance.
    for (int c = 0; c < NVEC + PD - 1; c++) begin
      if (c < NVEC) begin
        bus_if.in_valid = 1'b1;
        bus_if.selector = vecs[c].sel;
        bus_if.words_in = vecs[c].words;
      end else begin
        bus_if.in_valid = 1'b0;
      end
      tick();
      if (c >= PD - 1) begin
        check("vec_out_valid", bus_if.out_valid, 1);
        check("vec_word_out", bus_if.word_out, vecs[c-PD+1].exp_word);
        check("vec_out_of_range", bus_if.out_of_range, vecs[c-PD+1].exp_oor);
      end
    end
    bus_if.in_valid = 1'b0;
    tick();
    check("vec_drained", bus_if.out_valid, 0);
`ifdef MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN
    check("err_count_three", error_count, 3);
`endif

    // Backpressure: fill both stages, stall, then release with C waiting.
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.words_in  = W_SEQ;
    bus_if.selector  = 3'd0;
    tick();
    bus_if.selector = 3'd1;
    tick();
    bus_if.selector = 3'd2;
    #1;
    check("bp_full_in_ready", bus_if.in_ready, 0);
    check("bp_full_out_valid", bus_if.out_valid, 1);
    check("bp_full_word", bus_if.word_out, 8'h10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_stall_in_ready", bus_if.in_ready, 0);
      check("bp_stall_out_valid", bus_if.out_valid, 1);
      check("bp_stall_word", bus_if.word_out, 8'h10);
    end
    bus_if.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus_if.in_ready, 1);
    tick();
    check("bp_second_valid", bus_if.out_valid, 1);
    check("bp_second_word", bus_if.word_out, 8'h11);
    bus_if.in_valid = 1'b0;
    tick();
    check("bp_third_valid", bus_if.out_valid, 1);
    check("bp_third_word", bus_if.word_out, 8'h12);
    tick();
    check("bp_empty", bus_if.out_valid, 0);

    // Random valid/ready against a scoreboard.
    begin
      int  sent;
      int  recv;
      int  cyc;
      bit  fire_in;
      bit  fire_out;
      sb_t e;
      sent = 0;
      recv = 0;
      cyc  = 0;
      bus_if.in_valid = 1'b0;
      for (int n = 0; n < 30000 && recv < N_RAND; n++) begin
        if (!bus_if.in_valid && sent < N_RAND && $urandom_range(9) < 7) begin
          bus_if.in_valid = 1'b1;
          bus_if.selector = AW'($urandom_range(7));
          bus_if.words_in = 40'({$urandom(), $urandom()});
        end
        bus_if.out_ready = ($urandom_range(9) < 7);
        #1;
        fire_in  = bus_if.in_valid && bus_if.in_ready;
        fire_out = bus_if.out_valid && bus_if.out_ready;
        if (fire_out) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rand_unexpected actual=%h expected=none", {bus_if.out_of_range, bus_if.word_out});
          end else begin
            e = sb.pop_front();
            check("rand_data", {bus_if.out_of_range, bus_if.word_out}, e.res);
            check("rand_latency_ge_depth", 32'((cyc - e.cyc) >= PD), 1);
          end
          recv++;
        end
        if (fire_in) begin
          sb.push_back('{model(bus_if.selector, bus_if.words_in), cyc});
          sent++;
        end
        tick();
        cyc++;
        if (fire_in) bus_if.in_valid = 1'b0;
      end
      check("rand_received", recv, N_RAND);
      check("rand_sb_empty", sb.size(), 0);
    end

    // Mid-flight reset flushes two queued results.
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    tick();
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.words_in  = W_SEQ;
    bus_if.selector  = 3'd3;
    tick();
    bus_if.selector = 3'd4;
    tick();
    bus_if.in_valid = 1'b0;
    check("mid_inflight_valid", bus_if.out_valid, 1);
    check("mid_inflight_word", bus_if.word_out, 8'h13);
    clear_n = 1'b0;
    tick();
    check("mid_reset_out_valid", bus_if.out_valid, 0);
    check("mid_reset_word", bus_if.word_out, 0);
    clear_n          = 1'b1;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_flushed_idle", bus_if.out_valid, 0);
    end
`ifdef MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN
    check("err_count_cleared", error_count, 0);
`endif
    bus_if.in_valid = 1'b1;
    bus_if.selector = 3'd2;
    tick();
    bus_if.in_valid = 1'b0;
    check("mid_resume_latency", bus_if.out_valid, 0);
    tick();
    check("mid_resume_valid", bus_if.out_valid, 1);
    check("mid_resume_word", bus_if.word_out, 8'h12);
    check("mid_resume_oor", bus_if.out_of_range, 0);

`ifdef MULTIPLEXER_BINARY_PIPELINED_ERROR_COUNT_EN
    // Saturation: 65538 out-of-range acceptances from zero.
    bus_if.in_valid  = 1'b1;
    bus_if.selector  = 3'd7;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 65538; i++) begin
      tick();
    end
    bus_if.in_valid = 1'b0;
    tick();
    check("err_count_saturated", error_count, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
